bus_uart_bridge: RTL

- Bus initiator driven by a byte stream: decodes read/write command frames arriving from a UART receiver and issues single 32-bit transactions on the combined peripheral bus (bus_in/bus_out from bus_params.v).
- Returns a status byte or read data through a byte-level transmit handshake.
- Sits between a UART byte interface and the peripheral bus as its master. This gives a host serial link debug access to all bus peripherals, including bus_uart.

---
 rtl/bus_uart_bridge_pkg.sv | 37 +++
 rtl/bus_uart_bridge_timeout.sv | 32 +++
 rtl/bus_uart_bridge.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/bus_uart_bridge_pkg.sv
// Shared bus field layout, frame opcodes/replies and bridge FSM encoding.
package bus_uart_bridge_pkg;

  // Combined peripheral bus, request direction (bridge -> peripherals).
  localparam int unsigned BUS_FIELD_BE_START    = 0;
  localparam int unsigned BUS_FIELD_BE_END      = 4;
  localparam int unsigned BUS_FIELD_ADDR_START  = 4;
  localparam int unsigned BUS_FIELD_ADDR_END    = 36;
  localparam int unsigned BUS_FIELD_WDATA_START = 36;
  localparam int unsigned BUS_FIELD_WDATA_END   = 68;
  localparam int unsigned BUS_FIELD_RD_REQ      = 68;
  localparam int unsigned BUS_FIELD_WR_REQ      = 69;
  localparam int unsigned BUS_FIELD_RESET_L     = 70;
  localparam int unsigned BUS_FIELD_CLK         = 71;
  localparam int unsigned BUS_IN_WIDTH          = 72;

  // Return direction (peripherals -> bridge).
  localparam int unsigned BUS_RD_DATA_START = 0;
  localparam int unsigned BUS_RD_DATA_END   = 32;
  localparam int unsigned BUS_OUT_WIDTH     = 32;

  localparam logic [7:0] OP_WRITE  = 8'h57;
  localparam logic [7:0] OP_READ   = 8'h52;
  localparam logic [7:0] REPLY_OK  = 8'h2B;
  localparam logic [7:0] REPLY_BAD = 8'h3F;

  typedef enum logic [2:0] {
    StIdle,
    StGetAddr,
    StGetWdata,
    StBusWr,
    StBusRd,
    StRdWait,
    StSendByte
  } state_e;

endpackage

// File: rtl/bus_uart_bridge_timeout.sv
// Inter-byte watchdog: counts enabled idle cycles and pulses expired at the limit.
module bridge_timeout_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        enable,
  input  logic [31:0] limit,
  output logic        expired
);

  logic [31:0] cnt_q, cnt_d;

  assign expired = enable && !clear && (cnt_q == limit);

  always_comb begin
    cnt_d = cnt_q;
    if (clear || !enable) begin
      cnt_d = '0;
    end else if (!expired) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bus_uart_bridge.sv
// Byte-stream command decoder acting as single-transaction master on the peripheral bus.
module bus_uart_bridge
  import bus_uart_bridge_pkg::*;
#(
  parameter int unsigned RD_LATENCY     = 1,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1152000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic [BUS_IN_WIDTH-1:0]  bus_in,
  input  logic [BUS_OUT_WIDTH-1:0] bus_out,
  output logic                     busy
);

  state_e      state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic        is_write_q, is_write_d;
  logic [31:0] addr_sh_q, addr_sh_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] tx_buf_q, tx_buf_d;
  logic [3:0]  lat_cnt_q, lat_cnt_d;
  logic [2:0]  tx_left_q, tx_left_d;
  logic        tx_valid_q, tx_valid_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tmo_enable, tmo_expired;

  assign tmo_enable = (state_q == StGetAddr) || (state_q == StGetWdata);

  bridge_timeout_counter u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (rx_valid),
    .enable (tmo_enable),
    .limit  (TIMEOUT_CYCLES),
    .expired(tmo_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      byte_cnt_q <= '0;
      is_write_q <= 1'b0;
      addr_sh_q  <= '0;
      bus_addr_q <= '0;
      wdata_q    <= '0;
      tx_buf_q   <= '0;
      lat_cnt_q  <= '0;
      tx_left_q  <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      is_write_q <= is_write_d;
      addr_sh_q  <= addr_sh_d;
      bus_addr_q <= bus_addr_d;
      wdata_q    <= wdata_d;
      tx_buf_q   <= tx_buf_d;
      lat_cnt_q  <= lat_cnt_d;
      tx_left_q  <= tx_left_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    is_write_d = is_write_q;
    addr_sh_d  = addr_sh_q;
    bus_addr_d = bus_addr_q;
    wdata_d    = wdata_q;
    tx_buf_d   = tx_buf_q;
    lat_cnt_d  = lat_cnt_q;
    tx_left_d  = tx_left_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    unique case (state_q)
      StIdle: begin
        if (rx_valid) begin
          if (rx_data == OP_WRITE || rx_data == OP_READ) begin
            is_write_d = (rx_data == OP_WRITE);
            byte_cnt_d = '0;
            state_d    = StGetAddr;
          end else begin
            tx_buf_d  = {REPLY_BAD, 24'h0};
            tx_left_d = 3'd1;
            state_d   = StSendByte;
          end
        end
      end
      StGetAddr: begin
        if (rx_valid) begin
          addr_sh_d  = {addr_sh_q[23:0], rx_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            if (is_write_q) begin
              state_d = StGetWdata;
            end else begin
              bus_addr_d = addr_sh_d;
              state_d    = StBusRd;
            end
          end
        end else if (tmo_expired) begin
          state_d = StIdle;
        end
      end
      StGetWdata: begin
        if (rx_valid) begin
          wdata_d    = {wdata_q[23:0], rx_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            bus_addr_d = addr_sh_q;
            state_d    = StBusWr;
          end
        end else if (tmo_expired) begin
          state_d = StIdle;
        end
      end
      StBusWr: begin
        tx_buf_d  = {REPLY_OK, 24'h0};
        tx_left_d = 3'd1;
        state_d   = StSendByte;
      end
      StBusRd: begin
        lat_cnt_d = 4'd1;
        state_d   = StRdWait;
      end
      StRdWait: begin
        if (lat_cnt_q == 4'(RD_LATENCY)) begin
          tx_buf_d  = bus_out[BUS_RD_DATA_END-1:BUS_RD_DATA_START];
          tx_left_d = 3'd4;
          state_d   = StSendByte;
        end else begin
          lat_cnt_d = lat_cnt_q + 4'd1;
        end
      end
      StSendByte: begin
        // Present the next byte when nothing is on the port or the current one was taken.
        if (!tx_valid_q || (tx_ready && tx_left_q != 3'd0)) begin
          tx_valid_d = 1'b1;
          tx_data_d  = tx_buf_q[31:24];
          tx_buf_d   = {tx_buf_q[23:0], 8'h0};
          tx_left_d  = tx_left_q - 3'd1;
        end else if (tx_ready) begin
          tx_valid_d = 1'b0;
          tx_data_d  = '0;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus_in = '0;
    bus_in[BUS_FIELD_ADDR_END-1:BUS_FIELD_ADDR_START] = bus_addr_q;
    if (state_q == StBusWr) begin
      bus_in[BUS_FIELD_BE_END-1:BUS_FIELD_BE_START]       = 4'hF;
      bus_in[BUS_FIELD_WDATA_END-1:BUS_FIELD_WDATA_START] = wdata_q;
      bus_in[BUS_FIELD_WR_REQ]                            = 1'b1;
    end
    bus_in[BUS_FIELD_RD_REQ]  = (state_q == StBusRd);
    bus_in[BUS_FIELD_RESET_L] = ~reset;
    bus_in[BUS_FIELD_CLK]     = clk;
    tx_valid = tx_valid_q;
    tx_data  = tx_data_q;
    busy     = (state_q != StIdle);
  end

endmodule
